ahb_decoder_mux: RTL and testbench

- AHB-Lite address decoder, slave read-data/response multiplexer and built-in default slave.
- Sits between the single bus master (processor) and up to four AHB-Lite slaves; slot 1 is the LED peripheral.
- Generates per-slave HSEL in the address phase and routes HRDATA/HREADYOUT/HRESP back in the data phase.
- Unmapped addresses get a protocol-correct two-cycle ERROR response.

---
 rtl/ahb_decoder_mux_if.sv | 59 +++++
 rtl/ahb_decoder_mux.sv | 184 ++++++++++++++++++
 tb/tb_ahb_decoder_mux.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_decoder_mux_if.sv
// Bus bundle between the AHB-Lite master, the decoder/mux and up to four slaves.
// Optional DECODE_ERR_CAPTURE_EN adds the ERR_ADDR / ERR_CNT capture outputs.
interface ahb_decoder_mux_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;

  logic        HSEL_S0;
  logic        HSEL_S1;
  logic        HSEL_S2;
  logic        HSEL_S3;

  logic [31:0] HRDATA_S0;
  logic [31:0] HRDATA_S1;
  logic [31:0] HRDATA_S2;
  logic [31:0] HRDATA_S3;
  logic        HREADYOUT_S0;
  logic        HREADYOUT_S1;
  logic        HREADYOUT_S2;
  logic        HREADYOUT_S3;
  logic        HRESP_S0;
  logic        HRESP_S1;
  logic        HRESP_S2;
  logic        HRESP_S3;

  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

`ifdef DECODE_ERR_CAPTURE_EN
  logic [31:0] ERR_ADDR;
  logic [7:0]  ERR_CNT;
`endif

  // Decoder/mux side of the bundle.
  modport slave (
    input  HADDR, HTRANS,
    input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
    input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
    input  HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3,
    output HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3,
    output HREADY, HRDATA, HRESP
`ifdef DECODE_ERR_CAPTURE_EN
    , output ERR_ADDR, ERR_CNT
`endif
  );

  // Master and slave-peripheral side of the bundle.
  modport master (
    output HADDR, HTRANS,
    output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
    output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
    output HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3,
    input  HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3,
    input  HREADY, HRDATA, HRESP
`ifdef DECODE_ERR_CAPTURE_EN
    , input ERR_ADDR, ERR_CNT
`endif
  );
endinterface

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder, response mux and two-cycle ERROR default slave.
// Define DECODE_ERR_CAPTURE_EN to add unmapped-address capture (ERR_ADDR, ERR_CNT).
module ahb_decoder_mux #(
  parameter logic [7:0] S0_BASE = 8'h00,
  parameter logic [7:0] S1_BASE = 8'h50,
  parameter logic [7:0] S2_BASE = 8'h51,
  parameter logic [7:0] S3_BASE = 8'h52
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_decoder_mux_if.slave bus
);

  typedef enum logic [2:0] {
    SEL_S0   = 3'd0,
    SEL_S1   = 3'd1,
    SEL_S2   = 3'd2,
    SEL_S3   = 3'd3,
    SEL_DEF  = 3'd4,
    SEL_NONE = 3'd5
  } sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } def_state_t;

  localparam logic [7:0] BASE [4] = '{S0_BASE, S1_BASE, S2_BASE, S3_BASE};

  logic [3:0]  match;
  logic [31:0] rdata_s [4];
  logic [3:0]  ready_s;
  logic [3:0]  resp_s;

  sel_t        dec_sel;
  sel_t        sel_d;
  sel_t        sel_q;
  def_state_t  state_q;
  logic        def_hready_q;
  logic        def_hresp_q;

  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic        err_accept;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_match
      assign match[gi] = (bus.HADDR[31:24] == BASE[gi]);
    end
  endgenerate

  assign rdata_s[0] = bus.HRDATA_S0;
  assign rdata_s[1] = bus.HRDATA_S1;
  assign rdata_s[2] = bus.HRDATA_S2;
  assign rdata_s[3] = bus.HRDATA_S3;
  assign ready_s    = {bus.HREADYOUT_S3, bus.HREADYOUT_S2, bus.HREADYOUT_S1, bus.HREADYOUT_S0};
  assign resp_s     = {bus.HRESP_S3, bus.HRESP_S2, bus.HRESP_S1, bus.HRESP_S0};

  // Lowest index wins when bases overlap, so at most one select is ever high.
  always_comb begin
    dec_sel = SEL_DEF;
    if (match[0])      dec_sel = SEL_S0;
    else if (match[1]) dec_sel = SEL_S1;
    else if (match[2]) dec_sel = SEL_S2;
    else if (match[3]) dec_sel = SEL_S3;
  end

  assign bus.HSEL_S0 = (dec_sel == SEL_S0);
  assign bus.HSEL_S1 = (dec_sel == SEL_S1);
  assign bus.HSEL_S2 = (dec_sel == SEL_S2);
  assign bus.HSEL_S3 = (dec_sel == SEL_S3);

  assign err_accept = (dec_sel == SEL_DEF) && bus.HTRANS[1] && hready;

  always_comb begin
    sel_d = sel_q;
    if (hready) sel_d = dec_sel;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) sel_q <= SEL_NONE;
    else          sel_q <= sel_d;
  end

  // Outputs are registered alongside the state so they line up with it.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      def_hready_q <= 1'b1;
      def_hresp_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (err_accept) begin
            state_q      <= ST_ERR1;
            def_hready_q <= 1'b0;
            def_hresp_q  <= 1'b1;
          end
        end
        ST_ERR1: begin
          state_q      <= ST_ERR2;
          def_hready_q <= 1'b1;
          def_hresp_q  <= 1'b1;
        end
        ST_ERR2: begin
          if (err_accept) begin
            state_q      <= ST_ERR1;
            def_hready_q <= 1'b0;
            def_hresp_q  <= 1'b1;
          end else begin
            state_q      <= ST_IDLE;
            def_hready_q <= 1'b1;
            def_hresp_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          def_hready_q <= 1'b1;
          def_hresp_q  <= 1'b0;
        end
      endcase
    end
  end

  // Data-phase mux follows the registered selection, never the live decode.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    case (sel_q)
      SEL_S0, SEL_S1, SEL_S2, SEL_S3: begin
        hready = ready_s[sel_q[1:0]];
        hresp  = resp_s[sel_q[1:0]];
        hrdata = rdata_s[sel_q[1:0]];
      end
      SEL_DEF: begin
        hready = def_hready_q;
        hresp  = def_hresp_q;
      end
      default: ;
    endcase
  end

  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = hrdata;

`ifdef DECODE_ERR_CAPTURE_EN
  logic [31:0] err_addr_d;
  logic [31:0] err_addr_q;
  logic [7:0]  err_cnt_d;
  logic [7:0]  err_cnt_q;

  always_comb begin
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (err_accept) begin
      err_addr_d = bus.HADDR;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      err_addr_q <= 32'h0;
      err_cnt_q  <= 8'h0;
    end else begin
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.ERR_ADDR = err_addr_q;
  assign bus.ERR_CNT  = err_cnt_q;
`endif

  // Low address bits and HTRANS[0] never influence decode.
  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[23:0], bus.HTRANS[0]};

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Bench for ahb_decoder_mux: directed scenarios then random traffic, checked
// against a transfer-level model of decode, slot responses and the ERROR pair.
module tb_ahb_decoder_mux;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  ahb_decoder_mux_if bus ();

  ahb_decoder_mux dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Slave-side stimulus applied on the next step.
  logic [31:0] s_rdata [4];
  logic        s_rdy   [4];
  logic        s_rsp   [4];

  // Model: which target owns the data phase (-1 = nobody/zero-wait OKAY,
  // 0..3 = slot, 4 = ERROR response) and how many ERROR cycles remain.
  bit          m_valid = 0;
  int          m_owner = -1;
  int          m_err_left = 0;
  logic [31:0] m_err_addr = 32'h0;
  logic [7:0]  m_err_cnt  = 8'h0;

  function automatic int decode(input logic [31:0] a);
    case (a[31:24])
      8'h00:   return 0;
      8'h50:   return 1;
      8'h51:   return 2;
      8'h52:   return 3;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_slaves_ready();
    for (int k = 0; k < 4; k++) begin
      s_rdata[k] = 32'h1111_1111 * (k + 1);
      s_rdy[k]   = 1'b1;
      s_rsp[k]   = 1'b0;
    end
  endtask

  // One bus cycle: drive at the falling edge, check mid-cycle, advance model at the rising edge.
  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic r);
    int          dec;
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_data;
    @(negedge HCLK);
    HRESETn          = r;
    bus.HADDR        = a;
    bus.HTRANS       = t;
    bus.HRDATA_S0    = s_rdata[0];
    bus.HRDATA_S1    = s_rdata[1];
    bus.HRDATA_S2    = s_rdata[2];
    bus.HRDATA_S3    = s_rdata[3];
    bus.HREADYOUT_S0 = s_rdy[0];
    bus.HREADYOUT_S1 = s_rdy[1];
    bus.HREADYOUT_S2 = s_rdy[2];
    bus.HREADYOUT_S3 = s_rdy[3];
    bus.HRESP_S0     = s_rsp[0];
    bus.HRESP_S1     = s_rsp[1];
    bus.HRESP_S2     = s_rsp[2];
    bus.HRESP_S3     = s_rsp[3];
    #1;
    dec = decode(a);
    chk("hsel_s0", 32'(bus.HSEL_S0), 32'(dec == 0));
    chk("hsel_s1", 32'(bus.HSEL_S1), 32'(dec == 1));
    chk("hsel_s2", 32'(bus.HSEL_S2), 32'(dec == 2));
    chk("hsel_s3", 32'(bus.HSEL_S3), 32'(dec == 3));
    e_rdy  = 1'b1;
    e_rsp  = 1'b0;
    e_data = 32'h0;
    if (m_owner >= 0 && m_owner < 4) begin
      e_rdy  = s_rdy[m_owner];
      e_rsp  = s_rsp[m_owner];
      e_data = s_rdata[m_owner];
    end else if (m_owner == 4) begin
      e_rdy  = (m_err_left == 1);
      e_rsp  = 1'b1;
    end
    if (m_valid) begin
      chk("hready", 32'(bus.HREADY), 32'(e_rdy));
      chk("hresp", 32'(bus.HRESP), 32'(e_rsp));
      chk("hrdata", bus.HRDATA, e_data);
`ifdef DECODE_ERR_CAPTURE_EN
      chk("err_addr", bus.ERR_ADDR, m_err_addr);
      chk("err_cnt", 32'(bus.ERR_CNT), 32'(m_err_cnt));
`endif
    end
    @(posedge HCLK);
    if (!r) begin
      m_valid    = 1;
      m_owner    = -1;
      m_err_left = 0;
      m_err_addr = 32'h0;
      m_err_cnt  = 8'h0;
    end else if (e_rdy) begin
      if (dec < 4) begin
        m_owner = dec;
      end else if (t[1]) begin
        m_owner    = 4;
        m_err_left = 2;
        m_err_addr = a;
        if (m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
      end else begin
        m_owner = -1;
      end
    end else if (m_owner == 4) begin
      m_err_left = 1;
    end
  endtask

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  initial begin
    logic [31:0] a;
    logic [1:0]  t;
    set_slaves_ready();

    // Reset for two edges, then idle with reset released.
    step(32'h5000_0000, IDLE, 1'b0);
    step(32'h5000_0000, IDLE, 1'b0);
    step(32'h0000_0000, IDLE, 1'b1);

    // LED slot write: A5 returned in the data phase, HREADY follows slot 1.
    s_rdata[1] = 32'h0000_00A5;
    step(32'h5000_0000, NSEQ, 1'b1);
    s_rdy[1] = 1'b0;
    step(32'h0000_0000, IDLE, 1'b1);
    s_rdy[1] = 1'b1;
    step(32'h0000_0000, IDLE, 1'b1);

    // Slot 0 read with three wait states; the next address is held meanwhile.
    step(32'h0000_0010, NSEQ, 1'b1);
    s_rdy[0] = 1'b0;
    repeat (3) step(32'h5000_0004, NSEQ, 1'b1);
    s_rdy[0] = 1'b1;
    step(32'h5000_0004, NSEQ, 1'b1);
    step(32'h0000_0000, IDLE, 1'b1);

    // Unmapped NONSEQ gives the ERROR pair; unmapped IDLE is a plain OKAY.
    step(32'h9000_0000, NSEQ, 1'b1);
    step(32'h9000_0000, IDLE, 1'b1);
    step(32'h9000_0000, IDLE, 1'b1);
    step(32'h9000_0000, IDLE, 1'b1);

    // Back-to-back S1 -> unmapped -> S0 with distinct data per slot.
    s_rdata[0] = 32'hDEAD_0000;
    s_rdata[1] = 32'h0000_BEEF;
    step(32'h5000_0008, NSEQ, 1'b1);
    step(32'h9000_0000, NSEQ, 1'b1);
    step(32'h0000_0020, NSEQ, 1'b1);
    step(32'h0000_0020, NSEQ, 1'b1);
    step(32'h0000_0000, IDLE, 1'b1);
    step(32'h0000_0000, IDLE, 1'b1);

    // Reset while in ERR1, then recovery.
    step(32'h9000_0000, NSEQ, 1'b1);
    step(32'h0000_0000, IDLE, 1'b0);
    step(32'h0000_0000, IDLE, 1'b1);

    // Back-to-back unmapped SEQ from ERR2 straight into another ERR1.
    step(32'hA000_0000, NSEQ, 1'b1);
    step(32'hA000_0004, SEQ, 1'b1);
    step(32'hA000_0004, SEQ, 1'b1);
    step(32'hA000_0008, SEQ, 1'b1);
    step(32'hA000_0008, SEQ, 1'b1);
    step(32'h0000_0000, IDLE, 1'b1);

    // 300 unmapped NONSEQs drive the capture counter into saturation.
    for (int n = 0; n < 300; n++) begin
      a = 32'h9000_0000 + 32'(n * 4);
      step(a, NSEQ, 1'b1);
      step(a, NSEQ, 1'b1);
    end
    step(32'h0000_0000, IDLE, 1'b1);
    step(32'h0000_0000, IDLE, 1'b1);
`ifdef DECODE_ERR_CAPTURE_EN
    chk("err_cnt_sat", 32'(bus.ERR_CNT), 32'h0000_00FF);
`endif

    // Random traffic with random slave responses and occasional reset.
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 5))
        0:       a = {8'h00, 24'($urandom)};
        1:       a = {8'h50, 24'($urandom)};
        2:       a = {8'h51, 24'($urandom)};
        3:       a = {8'h52, 24'($urandom)};
        default: a = $urandom;
      endcase
      t = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        s_rdata[k] = $urandom;
        s_rdy[k]   = ($urandom_range(0, 3) != 0);
        s_rsp[k]   = ($urandom_range(0, 7) == 0);
      end
      step(a, t, ($urandom_range(0, 63) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
